// File: rtl/fpu_prenorm.sv
// ============================================================================
// Module   : fpu_prenorm
// Brief    : Normalises subnormal single-precision operands by left-shifting the
//            significand and lowering a widened signed exponent. Define
//            FPU_PRENORM_FAST_EN for up to 4-bit shifts per cycle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fpu_prenorm (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic        sign_i,
    input  logic [7:0]  exp_i,
    input  logic [23:0] sig_i,
    input  logic        isSubnormal_i,
    input  logic        isZero_i,
    input  logic        isInf_i,
    input  logic        isNaN_i,
    input  logic        isSignaling_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        sign_o,
    output logic [9:0]  exp_o,
    output logic [23:0] sig_o,
    output logic        isSubnormal_o,
    output logic        isZero_o,
    output logic        isInf_o,
    output logic        isNaN_o,
    output logic        isSignaling_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_sign;
    logic [9:0]  r_exp;
    logic [23:0] r_sig;
    logic [4:0]  r_flags;

    logic        w_accept;
    logic        w_load;
    logic        w_shift;
    logic [2:0]  w_sh;
    logic [23:0] w_sig_sh;
    logic [9:0]  w_exp_sh;

`ifdef FPU_PRENORM_FAST_EN
    // Shift by the leading-zero count of the top nibble, capped at 4.
    always_comb begin
        casez (r_sig[23:20])
            4'b1???: w_sh = 3'd0;
            4'b01??: w_sh = 3'd1;
            4'b001?: w_sh = 3'd2;
            4'b0001: w_sh = 3'd3;
            default: w_sh = 3'd4;
        endcase
    end
`else
    assign w_sh = 3'd1;
`endif

    assign w_sig_sh = r_sig << w_sh;
    assign w_exp_sh = r_exp - {7'd0, w_sh};

    assign ready_o  = (r_state == IDLE) | ((r_state == HOLD) & ready_i);
    assign valid_o  = (r_state == HOLD);
    assign w_accept = valid_i & ready_o;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_load      = 1'b1;
                    w_state_nxt = isSubnormal_i ? SHIFT : HOLD;
                end
            end
            SHIFT: begin
                // A zero significand can never normalise; release it rather than spin.
                w_shift = (r_sig != 24'd0);
                if (w_sig_sh[23] || (r_sig == 24'd0)) begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (ready_i) begin
                    if (w_accept) begin
                        w_load      = 1'b1;
                        w_state_nxt = isSubnormal_i ? SHIFT : HOLD;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_sign  <= 1'b0;
            r_exp   <= 10'd0;
            r_sig   <= 24'd0;
            r_flags <= 5'd0;
        end else if (w_load) begin
            r_sign  <= sign_i;
            r_exp   <= {2'b00, exp_i};
            r_sig   <= sig_i;
            r_flags <= {isSubnormal_i, isZero_i, isInf_i, isNaN_i, isSignaling_i};
        end else if (w_shift) begin
            r_sig   <= w_sig_sh;
            r_exp   <= w_exp_sh;
        end
    end

    assign sign_o        = r_sign;
    assign exp_o         = r_exp;
    assign sig_o         = r_sig;
    assign isSubnormal_o = r_flags[4];
    assign isZero_o      = r_flags[3];
    assign isInf_o       = r_flags[2];
    assign isNaN_o       = r_flags[1];
    assign isSignaling_o = r_flags[0];

endmodule

`default_nettype wire
